// File: rtl/rob_pkg.sv
// Shared ROB-side types and sizing constants for the issue path.
package rob_pkg;

  localparam int unsigned ROB_ENTRIES     = 64;
  localparam int unsigned ROB_PTR_W       = $clog2(ROB_ENTRIES);
  localparam int unsigned UOP_W           = 16;
  localparam int unsigned IQ_DEPTH        = 8;
  localparam int unsigned IQ_MAX_INFLIGHT = 4;

  typedef logic [ROB_PTR_W-1:0] rob_ptr_t;

  // Uop plus the ROB entry it belongs to
  typedef struct packed {
    logic [UOP_W-1:0] uop;
    rob_ptr_t         ptr;
  } rob_issue;

  typedef enum logic [1:0] {
    READY     = 2'd0,
    DONE      = 2'd1,
    EXCEPTION = 2'd2
  } status_t;

endpackage

// File: rtl/issue_fifo.sv
// Circular buffer of issue packets with push/pop and an occupancy count.
// The caller guarantees no push when full and no pop when empty.
module issue_fifo
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  rob_issue               push_data,
  input  logic                   pop,
  output rob_issue               head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  rob_issue      mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  assign head_data = mem[head];

  // Storage write at the tail; contents are not cleared by reset or flush
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Issue queue between the ROB and one functional unit: buffers packets,
// limits dispatched-but-uncompleted uops, and forwards completions.
module issue_queue
  import rob_pkg::*;
#(
  parameter int unsigned IQ_DEPTH     = rob_pkg::IQ_DEPTH,
  parameter int unsigned MAX_INFLIGHT = rob_pkg::IQ_MAX_INFLIGHT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      rob_issue_valid,
  input  rob_issue                  rob_issue_data,
  output logic                      rob_issue_ready,
  output logic                      fu_valid,
  output rob_issue                  fu_data,
  input  logic                      fu_ready,
  input  logic                      fu_done_valid,
  input  logic [ROB_PTR_W-1:0]      fu_done_ptr,
  input  logic                      fu_done_exception,
  output logic                      rob_complete_valid,
  output logic [ROB_PTR_W-1:0]      rob_complete_ptr,
  output status_t                   rob_complete_status,
  output logic [$clog2(IQ_DEPTH):0] occupancy
);

  localparam int unsigned OCC_W = $clog2(IQ_DEPTH) + 1;
  localparam int unsigned IF_W  = $clog2(MAX_INFLIGHT + 1);
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(IQ_DEPTH);
  localparam logic [IF_W-1:0]  MAX_C   = IF_W'(MAX_INFLIGHT);

  logic [IF_W-1:0] inflight;
  logic            enq;
  logic            dispatch;

  assign rob_issue_ready = (occupancy != DEPTH_C) && !flush;
  assign fu_valid        = (occupancy != '0) && (inflight != MAX_C) && !flush;
  assign enq             = rob_issue_valid && rob_issue_ready;
  assign dispatch        = fu_valid && fu_ready;

  issue_fifo #(
    .DEPTH(IQ_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (enq),
    .push_data(rob_issue_data),
    .pop      (dispatch),
    .head_data(fu_data),
    .count    (occupancy)
  );

  // Inflight count: dispatch and completion in the same cycle cancel out
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      inflight <= '0;
    end else if (dispatch && !fu_done_valid) begin
      inflight <= inflight + 1'b1;
    end else if (fu_done_valid && !dispatch && (inflight != '0)) begin
      inflight <= inflight - 1'b1;
    end
  end

  // Completion register, forwarded regardless of the inflight count
  always_ff @(posedge clk) begin
    if (rst) begin
      rob_complete_valid  <= 1'b0;
      rob_complete_ptr    <= '0;
      rob_complete_status <= READY;
    end else begin
      rob_complete_valid  <= fu_done_valid && !flush;
      rob_complete_ptr    <= fu_done_ptr;
      rob_complete_status <= fu_done_exception ? EXCEPTION : DONE;
    end
  end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default rob_pkg::IQ_DEPTH (8), the number of buffered issue entries; power of two, at least 2.
REQ-002 SHALL have parameter MAX_INFLIGHT, default rob_pkg::IQ_MAX_INFLIGHT (4), the limit on dispatched-but-uncompleted uops.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush  input  1  pipeline flush; discards all buffered and in-flight tracking state.
REQ-006 SHALL have port rob_issue_valid  input  1  the ROB is presenting an issue packet.
REQ-007 SHALL have port rob_issue_data  input  rob_pkg::rob_issue  the issue packet (uop plus ROB ptr).
REQ-008 SHALL have port rob_issue_ready  output  1  the queue accepts a packet this cycle.
REQ-009 SHALL have port fu_valid  output  1  a head entry is offered to the functional unit.
REQ-010 SHALL have port fu_data  output  rob_pkg::rob_issue  the head entry.
REQ-011 SHALL have port fu_ready  input  1  the FU accepts fu_data this cycle.
REQ-012 SHALL have port fu_done_valid  input  1  the FU reports completion of one uop.
REQ-013 SHALL have port fu_done_ptr  input  $clog2(ROB_ENTRIES)  ROB ptr of the completed uop.
REQ-014 SHALL have port fu_done_exception  input  1  the completed uop raised an exception.
REQ-015 SHALL have port rob_complete_valid  output  1  completion report to the ROB.
REQ-016 SHALL have port rob_complete_ptr  output  $clog2(ROB_ENTRIES)  ROB entry being completed.
REQ-017 SHALL have port rob_complete_status  output  rob_pkg::status_t  DONE or EXCEPTION.
REQ-018 SHALL have port occupancy  output  $clog2(IQ_DEPTH)+1  number of buffered entries.

Function
REQ-019 Enqueue SHALL occur when rob_issue_valid && rob_issue_ready; the entry is written at the tail and the tail pointer advances modulo IQ_DEPTH.
REQ-020 rob_issue_ready SHALL be (occupancy != IQ_DEPTH) && !flush; there is no same-cycle full bypass.
REQ-021 fu_valid SHALL be (occupancy != 0) && (inflight != MAX_INFLIGHT) && !flush; fu_data SHALL be the head entry, driven combinationally from storage.
REQ-022 Dispatch SHALL occur when fu_valid && fu_ready; the head pointer advances modulo IQ_DEPTH and inflight increments.
REQ-023 Simultaneous enqueue and dispatch SHALL leave occupancy unchanged; occupancy SHALL never exceed IQ_DEPTH or go below 0.
REQ-024 Entries SHALL dispatch in enqueue order; minimum latency from enqueue to fu_valid is 1 cycle, with no empty bypass.
REQ-025 When fu_done_valid is high, inflight SHALL decrement, saturating at 0. A dispatch in the same cycle SHALL leave inflight unchanged.
REQ-026 Completion SHALL be registered with 1-cycle latency: rob_complete_valid <= fu_done_valid && !flush; ptr <= fu_done_ptr; status <= EXCEPTION if fu_done_exception, else DONE.
REQ-027 A completion SHALL be forwarded even when inflight is 0.
REQ-028 Flush SHALL take priority over enqueue, dispatch and completion. On the next cycle, head, tail, occupancy and inflight SHALL be 0, and rob_complete_valid SHALL be 0.
REQ-029 Head and tail pointers SHALL wrap from IQ_DEPTH-1 to 0 without loss or duplication of entries.

Reset
REQ-030 On rst, head, tail, occupancy and inflight SHALL be 0, and rob_complete_valid SHALL be 0.
REQ-031 On rst, rob_complete_ptr SHALL be 0 and rob_complete_status SHALL be READY.
REQ-032 During and after reset, fu_valid SHALL be 0 and rob_issue_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-033 Reset asserted mid-operation SHALL discard all entries with the same result as flush; storage contents need not be cleared.

Structure
REQ-034 Constants IQ_DEPTH and IQ_MAX_INFLIGHT SHALL live in rob_pkg; the rob_issue and status_t types from rob_pkg SHALL be reused, not redefined.
REQ-035 Buffer storage and pointers SHALL be one sub-module, issue_fifo (circular FIFO with push/pop/count). Inflight tracking and the completion register SHALL stay in issue_queue.

Verification
REQ-036 Enqueue ptr=5 with fu_ready=1 -> fu_valid rises the next cycle with fu_data.ptr=5; after dispatch, occupancy returns to 0.
REQ-037 Enqueue 8 entries with fu_ready=0 -> rob_issue_ready=0 and occupancy=8; a 9th valid is not accepted. Pop one -> ready returns to 1.
REQ-038 Push 20 entries (ptrs 0..19) with random fu_ready -> FU receives ptrs 0..19 in order, covering wrap of head and tail.
REQ-039 Dispatch 4 entries with no completions -> fu_valid=0 despite occupancy>0. A single fu_done_valid -> inflight=3 and fu_valid=1.
REQ-040 fu_done_valid with ptr=42 and exception=1 -> next cycle rob_complete_valid=1, ptr=42, status=EXCEPTION. The same with exception=0 -> status=DONE.
REQ-041 Occupancy 5 and inflight 2, then flush together with rob_issue_valid -> next cycle occupancy=0, inflight=0, fu_valid=0, and the flushed packet is not enqueued.
